// File: rtl/soc_cpu_dct_pkg.sv
// soc_cpu_dct_pkg: shared sizes, FSM states and frame record for the debug-trace packer
package soc_cpu_dct_pkg;
  localparam int ATOM_W = 2;
  localparam int SLOTS = 15;
  localparam int CNT_W = 4;
  localparam int BUF_W = ATOM_W * SLOTS;
  localparam int FCNT_W = 16;
  typedef enum logic [1:0] {RUN, DRAIN, ENDED} state_e;
  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic [BUF_W-1:0] data;
  } frame_t;
endpackage

// File: rtl/soc_cpu_dct_outreg.sv
// soc_cpu_dct_outreg: valid/ready holding register for one completed trace frame
module soc_cpu_dct_outreg
  import soc_cpu_dct_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  frame_t load_frame,
  input  logic   frame_ready,
  output logic   frame_valid,
  output frame_t frame
);
  logic valid_q, valid_d;
  frame_t frame_q, frame_d;
  always_comb begin
    valid_d = load | (valid_q & ~frame_ready);
    frame_d = load ? load_frame : frame_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      frame_q <= '0;
    end else begin
      valid_q <= valid_d;
      frame_q <= frame_d;
    end
  end
  assign frame_valid = valid_q;
  assign frame = frame_q;
  a_cnt_nonzero: assert property (@(posedge clk) disable iff (reset) valid_q |-> frame_q.cnt != 0);
endmodule

// File: rtl/soc_cpu_dct_packer.sv
// soc_cpu_dct_packer: packs 2-bit trace atoms into frames and sequences the end-of-test drain
module soc_cpu_dct_packer
  import soc_cpu_dct_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              atom_valid,
  input  logic [ATOM_W-1:0] atom,
  output logic              atom_ready,
  input  logic              flush,
  input  logic              test_ending,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              test_has_ended,
  output logic [FCNT_W-1:0] frame_total
);
  state_e state_q, state_d;
  logic [BUF_W-1:0] acc_buf_q, acc_buf_d, merged_buf;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d, merged_cnt;
  logic [FCNT_W-1:0] frame_total_q, frame_total_d;
  logic flush_pend_q, flush_pend_d;
  logic full, can_move, accept, req, move;
  frame_t load_frame, out_frame;
  always_comb begin
    full = acc_cnt_q == CNT_W'(SLOTS);
    can_move = ~frame_valid | frame_ready;
    atom_ready = ~reset & (state_q == RUN) & ~(full & frame_valid & ~frame_ready);
    accept = atom_valid & atom_ready;
    req = flush | flush_pend_q | test_ending | (state_q != RUN);
    // a full acc only accepts alongside its own move, so the atom is merged only when not full
    merged_buf = acc_buf_q | ((accept & ~full) ? BUF_W'(atom) << (ATOM_W * acc_cnt_q) : '0);
    merged_cnt = acc_cnt_q + CNT_W'(accept & ~full);
    move = can_move & (merged_cnt != 0) & ((merged_cnt == CNT_W'(SLOTS)) | req);
    load_frame = '{cnt: merged_cnt, data: merged_buf};
    acc_buf_d = move ? ((full & accept) ? BUF_W'(atom) : '0) : merged_buf;
    acc_cnt_d = move ? CNT_W'(full & accept) : merged_cnt;
    flush_pend_d = (flush | flush_pend_q) & ~move & (merged_cnt != 0);
    frame_total_d = frame_total_q + FCNT_W'(frame_valid & frame_ready);
    state_d = ((state_q == RUN) & test_ending) ? DRAIN :
              ((state_q == DRAIN) & (acc_cnt_q == 0) & ~frame_valid) ? ENDED : state_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      acc_buf_q <= '0;
      acc_cnt_q <= '0;
      flush_pend_q <= 1'b0;
      frame_total_q <= '0;
    end else begin
      state_q <= state_d;
      acc_buf_q <= acc_buf_d;
      acc_cnt_q <= acc_cnt_d;
      flush_pend_q <= flush_pend_d;
      frame_total_q <= frame_total_d;
    end
  end
  soc_cpu_dct_outreg u_outreg (
    .clk        (clk),
    .reset      (reset),
    .load       (move),
    .load_frame (load_frame),
    .frame_ready(frame_ready),
    .frame_valid(frame_valid),
    .frame      (out_frame)
  );
  assign dct_buffer = out_frame.data;
  assign dct_count = out_frame.cnt;
  assign test_has_ended = state_q == ENDED;
  assign frame_total = frame_total_q;
endmodule

// File: tb/tb_soc_cpu_dct_packer.sv
// tb_soc_cpu_dct_packer: randomized and directed checks against a frame-queue reference model
module tb_soc_cpu_dct_packer;
  logic clk = 1'b0;
  logic reset, atom_valid, flush, test_ending, frame_ready;
  logic [1:0] atom;
  logic atom_ready, frame_valid, test_has_ended;
  logic [29:0] dct_buffer;
  logic [3:0] dct_count;
  logic [15:0] frame_total;
  int tests = 0, fails = 0, acc_n = 0;
  logic [29:0] q_buf[$];
  int q_cnt[$];
  logic [29:0] p_buf;
  int p_n, m_total, m_st;

  soc_cpu_dct_packer dut (
    .clk(clk), .reset(reset), .atom_valid(atom_valid), .atom(atom), .atom_ready(atom_ready),
    .flush(flush), .test_ending(test_ending), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .test_has_ended(test_has_ended),
    .frame_total(frame_total)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: accepted atoms collect in a partial frame; closed frames queue until delivered.
  // The packer holds at most two closed frames, so it stalls only with two queued and no ready.
  always @(posedge clk) begin
    logic exp_rdy, done;
    if (reset) begin
      q_buf.delete(); q_cnt.delete();
      p_buf = '0; p_n = 0; m_total = 0; m_st = 0;
      chk("rst_ready", atom_ready, 0);
      chk("rst_valid", frame_valid, 0);
      chk("rst_buf", dct_buffer, 0);
      chk("rst_cnt", dct_count, 0);
      chk("rst_total", frame_total, 0);
      chk("rst_ended", test_has_ended, 0);
    end else begin
      exp_rdy = (m_st == 0) && !(q_cnt.size() == 2 && !frame_ready);
      chk("atom_ready", atom_ready, exp_rdy);
      chk("frame_valid", frame_valid, q_cnt.size() != 0);
      if (q_cnt.size() != 0 && frame_valid) begin
        chk("dct_buffer", dct_buffer, q_buf[0]);
        chk("dct_count", dct_count, q_cnt[0]);
      end
      chk("frame_total", frame_total, m_total & 16'hFFFF);
      chk("ended", test_has_ended, m_st == 2);
      done = (m_st == 1) && q_cnt.size() == 0 && p_n == 0;
      if (frame_valid && frame_ready && q_cnt.size() != 0) begin
        void'(q_buf.pop_front()); void'(q_cnt.pop_front()); m_total++;
      end
      if (atom_valid && exp_rdy) begin
        p_buf |= 30'(atom) << (2 * p_n);
        p_n++;
        if (p_n == 15) begin q_buf.push_back(p_buf); q_cnt.push_back(p_n); p_buf = '0; p_n = 0; end
      end
      if ((flush || m_st == 1 || (m_st == 0 && test_ending)) && p_n > 0) begin
        q_buf.push_back(p_buf); q_cnt.push_back(p_n); p_buf = '0; p_n = 0;
      end
      if (done) m_st = 2;
      else if (m_st == 0 && test_ending) m_st = 1;
    end
  end

  task automatic step(input logic v, input logic [1:0] a, input logic fl, input logic fr, input logic te);
    atom_valid = v; atom = a; flush = fl; frame_ready = fr; test_ending = te;
    #1;
    if (v && atom_ready) acc_n++;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic fr;
    reset = 1'b1; atom_valid = 0; atom = 0; flush = 0; test_ending = 0; frame_ready = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    // full frame of 2'b01
    for (int i = 0; i < 15; i++) step(1, 2'b01, 0, 1, 0);
    chk("t1_valid", frame_valid, 1);
    chk("t1_buf", dct_buffer, 30'h15555555);
    chk("t1_cnt", dct_count, 15);
    step(0, 0, 0, 1, 0);
    chk("t1_total", frame_total, 1);
    // partial frame closed by flush, then flush on an empty accumulator
    step(1, 3, 0, 1, 0); step(1, 2, 0, 1, 0); step(1, 1, 0, 1, 0); step(1, 0, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    chk("t2_valid", frame_valid, 1);
    chk("t2_buf", dct_buffer, 30'h0000001B);
    chk("t2_cnt", dct_count, 4);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    chk("t2_empty_flush", frame_valid, 0);
    chk("t2_total", frame_total, 2);
    // backpressure: two frames of capacity, then release
    acc_n = 0;
    for (int i = 0; i < 34; i++) step(1, 2'($urandom), 0, 0, 0);
    chk("t3_cap", acc_n, 30);
    chk("t3_stall", atom_ready, 0);
    for (int i = 0; i < 100 && acc_n < 40; i++) step(1, 2'($urandom), 0, 1, 0);
    chk("t3_all", acc_n, 40);
    step(0, 0, 1, 1, 0);
    repeat (4) step(0, 0, 0, 1, 0);
    chk("t3_total", frame_total, 5);
    // back-to-back: frame at N+1 and the 16th atom accepted without a stall
    acc_n = 0;
    for (int i = 0; i < 15; i++) step(1, 2'($urandom), 0, 1, 0);
    chk("t4_valid", frame_valid, 1);
    step(1, 2'($urandom), 0, 1, 0);
    chk("t4_nostall", acc_n, 16);
    chk("t4_valid_after", frame_valid, 0);
    step(0, 0, 1, 1, 0);
    repeat (2) step(0, 0, 0, 1, 0);
    chk("t4_total", frame_total, 7);
    // random traffic; flushes only while the FIFO is ready
    repeat (3000) begin
      fr = $urandom_range(0, 9) < 6;
      step($urandom_range(0, 9) < 7, 2'($urandom), fr && ($urandom_range(0, 19) == 0), fr, 0);
    end
    step(0, 0, 1, 1, 0);
    repeat (3) step(0, 0, 0, 1, 0);
    // reset with a pending frame and 9 atoms accumulated
    for (int i = 0; i < 24; i++) step(1, 2'($urandom), 0, 0, 0);
    chk("t6_pending", frame_valid, 1);
    reset = 1'b1;
    #1;
    chk("t6_async_valid", frame_valid, 0);
    chk("t6_async_buf", dct_buffer, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) step(1, 2'b10, 0, 1, 0);
    chk("t6_buf", dct_buffer, 30'h2AAAAAAA);
    chk("t6_cnt", dct_count, 15);
    step(0, 0, 0, 1, 0);
    chk("t6_total", frame_total, 1);
    // drain at test end
    for (int i = 0; i < 7; i++) step(1, 2'($urandom), 0, 1, 0);
    repeat (5) step(0, 0, 0, 0, 1);
    chk("t5_ready", atom_ready, 0);
    chk("t5_valid", frame_valid, 1);
    chk("t5_cnt", dct_count, 7);
    for (int i = 0; i < 20 && !test_has_ended; i++) step(0, 0, 0, 1, 1);
    chk("t5_ended", test_has_ended, 1);
    chk("t5_total", frame_total, 2);
    step(0, 0, 0, 1, 0);
    chk("t5_sticky", test_has_ended, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
